// File: rtl/stopwatch_lap_ctrl.sv
// 100 Hz SS.cc stopwatch core: up/down BCD counter, start/stop FSM, split display,
// lap memory and alarm/done flags, feeding the 7-segment display mux.
module stopwatch_lap_ctrl #(
    parameter int LAP_DEPTH  = 4,
    parameter int LAP_AW     = 2,
    parameter int ALARM_SEC  = 10,
    parameter int PRESET_SEC = 30
) (
    input  logic              clk_100hz,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic              split,
    input  logic              lap,
    input  logic              clear,
    input  logic              mode_down,
    input  logic [LAP_AW-1:0] lap_rd_idx,
    output logic [14:0]       disp_time,
    output logic [14:0]       lap_rd_time,
    output logic [LAP_AW:0]   lap_count,
    output logic              running,
    output logic              alarm,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    // Time is held as four BCD nibbles {sec_h, sec_l, cs_h, cs_l}; sec_h never exceeds 5.
    localparam logic [15:0] ZERO_T   = 16'h0000;
    localparam logic [15:0] ONE_T    = 16'h0001;
    localparam logic [15:0] ALARM_T  = {4'(ALARM_SEC / 10), 4'(ALARM_SEC % 10), 8'h00};
    localparam logic [15:0] PRESET_T = {4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10), 8'h00};
    localparam logic [LAP_AW:0] LAP_FULL = (LAP_AW + 1)'(LAP_DEPTH);

    state_t            state_q;
    logic              mode_q;
    logic [15:0]       time_q;
    logic [14:0]       disp_q;
    logic [LAP_AW:0]   lap_cnt_q;
    logic              running_q;
    logic              alarm_q;
    logic              done_q;
    logic [14:0]       lap_mem_q [LAP_DEPTH];

    logic [3:0]        at_edge;
    logic [3:0]        carry;
    logic [15:0]       step_d;
    logic [15:0]       reload_d;
    logic              wrap_d;
    logic              lap_wr;
    logic              reach_zero;

    // Each digit steps when every lower digit sits at its roll-over value
    // (max when counting up, zero when counting down).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DMAX  = (gi == 3) ? 4'd5 : 4'd9;
            localparam logic [3:0] LOWER = 4'((1 << gi) - 1);
            logic [3:0] nib;

            assign nib         = time_q[gi*4 +: 4];
            assign at_edge[gi] = mode_q ? (nib == 4'd0) : (nib == DMAX);
            assign carry[gi]   = &(at_edge | ~LOWER);
            assign step_d[gi*4 +: 4] = !carry[gi]  ? nib :
                                       at_edge[gi] ? (mode_q ? DMAX : 4'd0) :
                                       (mode_q ? nib - 4'd1 : nib + 4'd1);
        end
    endgenerate

    assign wrap_d     = &at_edge;
    assign reload_d   = mode_down ? PRESET_T : ZERO_T;
    assign reach_zero = mode_q && ((time_q == ONE_T) || (time_q == ZERO_T));
    assign lap_wr     = lap && !clear && (lap_cnt_q != LAP_FULL) &&
                        ((state_q == S_RUN) || (state_q == S_STOP));

    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            time_q    <= ZERO_T;
            disp_q    <= '0;
            lap_cnt_q <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
        end else if (clear) begin
            state_q   <= S_IDLE;
            mode_q    <= mode_down;
            time_q    <= reload_d;
            disp_q    <= reload_d[14:0];
            lap_cnt_q <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (!split) begin
                disp_q <= time_q[14:0];
            end
            if (lap_wr) begin
                lap_cnt_q <= lap_cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    mode_q <= mode_down;
                    time_q <= reload_d;
                    if (start_stop) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (reach_zero) begin
                        time_q    <= ZERO_T;
                        state_q   <= S_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        time_q <= step_d;
                        if (!mode_q && (step_d == ALARM_T)) begin
                            alarm_q <= 1'b1;
                        end else if (!mode_q && wrap_d) begin
                            alarm_q <= 1'b0;
                        end
                        if (start_stop) begin
                            state_q   <= S_STOP;
                            running_q <= 1'b0;
                        end
                    end
                end
                S_STOP: begin
                    if (start_stop) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    // Terminal until clear; start_stop is ignored here.
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    // Lap entries are written in arrival order and never overwritten once full.
    always_ff @(posedge clk_100hz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_mem_q[i] <= '0;
            end
        end else if (lap_wr) begin
            lap_mem_q[lap_cnt_q[LAP_AW-1:0]] <= time_q[14:0];
        end
    end

    assign lap_rd_time = ({1'b0, lap_rd_idx} < lap_cnt_q) ? lap_mem_q[lap_rd_idx] : 15'h0000;
    assign disp_time   = disp_q;
    assign lap_count   = lap_cnt_q;
    assign running     = running_q;
    assign alarm       = alarm_q;
    assign done        = done_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: a vector table for the up-count, lap and
// split behaviour, then hand-written countdown, alarm/wrap and async-reset sequences.
module tb_stopwatch_lap_ctrl;

    logic        clk_100hz = 1'b0;
    logic        rst_n;
    logic        start_stop;
    logic        split;
    logic        lap;
    logic        clear;
    logic        mode_down;
    logic [1:0]  lap_rd_idx;
    logic [14:0] disp_time;
    logic [14:0] lap_rd_time;
    logic [2:0]  lap_count;
    logic        running;
    logic        alarm;
    logic        done;

    int checks   = 0;
    int failures = 0;

    stopwatch_lap_ctrl #(
        .LAP_DEPTH (4),
        .LAP_AW    (2),
        .ALARM_SEC (10),
        .PRESET_SEC(30)
    ) dut (
        .clk_100hz  (clk_100hz),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .split      (split),
        .lap        (lap),
        .clear      (clear),
        .mode_down  (mode_down),
        .lap_rd_idx (lap_rd_idx),
        .disp_time  (disp_time),
        .lap_rd_time(lap_rd_time),
        .lap_count  (lap_count),
        .running    (running),
        .alarm      (alarm),
        .done       (done)
    );

    always #5 clk_100hz = ~clk_100hz;

    typedef struct {
        logic        ss;
        logic        lp;
        logic        sp;
        logic        clr;
        int          cyc;
        logic [1:0]  idx;
        logic [14:0] exp_disp;
        logic        exp_run;
        logic [2:0]  exp_cnt;
        logic [14:0] exp_lrd;
    } vec_t;

    vec_t tbl [21];

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100hz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        tick(1);
        start_stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_stop = 1'b0; split = 1'b0; lap = 1'b0;
        clear = 1'b0; mode_down = 1'b0; lap_rd_idx = 2'd0;

        // ss, lp, sp, clr, cycles, rd_idx, disp, running, lap_count, lap_rd_time
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 2'd0, 15'h0000, 1'b0, 3'd0, 15'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 2'd0, 15'h0000, 1'b1, 3'd0, 15'h0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,  10, 2'd0, 15'h0009, 1'b1, 3'd0, 15'h0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0,  10, 2'd0, 15'h0019, 1'b1, 3'd1, 15'h0010};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0,  10, 2'd1, 15'h0029, 1'b1, 3'd2, 15'h0020};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,  10, 2'd2, 15'h0039, 1'b1, 3'd3, 15'h0030};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,  10, 2'd3, 15'h0049, 1'b1, 3'd4, 15'h0040};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0,  10, 2'd0, 15'h0059, 1'b1, 3'd4, 15'h0010};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 191, 2'd3, 15'h0250, 1'b1, 3'd4, 15'h0040};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 2'd1, 15'h0251, 1'b0, 3'd4, 15'h0020};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  40, 2'd2, 15'h0252, 1'b0, 3'd4, 15'h0030};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 2'd3, 15'h0252, 1'b1, 3'd4, 15'h0040};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0,  49, 2'd0, 15'h0300, 1'b1, 3'd4, 15'h0010};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 100, 2'd1, 15'h0300, 1'b1, 3'd4, 15'h0020};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 2'd2, 15'h0401, 1'b1, 3'd4, 15'h0030};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 2'd0, 15'h0000, 1'b0, 3'd0, 15'h0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 2'd0, 15'h0000, 1'b1, 3'd0, 15'h0000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0,   5, 2'd0, 15'h0004, 1'b1, 3'd0, 15'h0000};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0,   1, 2'd0, 15'h0005, 1'b0, 3'd1, 15'h0005};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 2'd1, 15'h0006, 1'b0, 3'd2, 15'h0006};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1,   1, 2'd0, 15'h0000, 1'b0, 3'd0, 15'h0000};

        // Reset state
        tick(3);
        check("rst_disp", 32'(disp_time), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_lap_count", 32'(lap_count), 32'h0);
        check("rst_alarm_done", 32'({alarm, done}), 32'h0);
        rst_n = 1'b1;

        // Up-count, laps with overflow, stop/resume, split, clear, lap+stop together
        for (int i = 0; i < 21; i++) begin
            start_stop = tbl[i].ss;
            lap        = tbl[i].lp;
            split      = tbl[i].sp;
            clear      = tbl[i].clr;
            lap_rd_idx = tbl[i].idx;
            tick(1);
            start_stop = 1'b0;
            lap        = 1'b0;
            clear      = 1'b0;
            if (tbl[i].cyc > 1) tick(tbl[i].cyc - 1);
            check($sformatf("vec%0d_disp", i), 32'(disp_time), 32'(tbl[i].exp_disp));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
            check($sformatf("vec%0d_lap_count", i), 32'(lap_count), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_lap_rd", i), 32'(lap_rd_time), 32'(tbl[i].exp_lrd));
            check($sformatf("vec%0d_alarm_done", i), 32'({alarm, done}), 32'h0);
            $display("vec %0d: disp=%h running=%0d lap_count=%0d lap_rd[%0d]=%h",
                     i, disp_time, running, lap_count, lap_rd_idx, lap_rd_time);
        end
        split = 1'b0;

        // Countdown from 30.00 to DONE
        mode_down = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("cd_reload_disp", 32'(disp_time), 32'h3000);
        pulse_ss();
        check("cd_start_running", 32'(running), 32'h1);
        tick(2999);
        check("cd_00.01_done", 32'(done), 32'h0);
        check("cd_00.01_disp", 32'(disp_time), 32'h0002);
        tick(1);
        check("cd_done_flag", 32'(done), 32'h1);
        check("cd_done_running", 32'(running), 32'h0);
        check("cd_alarm_down", 32'(alarm), 32'h0);
        tick(1);
        check("cd_disp_zero", 32'(disp_time), 32'h0000);
        $display("countdown: disp=%h done=%0d running=%0d", disp_time, done, running);
        start_stop = 1'b1;
        lap = 1'b1;
        tick(1);
        start_stop = 1'b0;
        lap = 1'b0;
        tick(2);
        check("done_ss_ignored_run", 32'(running), 32'h0);
        check("done_ss_ignored_done", 32'(done), 32'h1);
        check("done_ss_ignored_disp", 32'(disp_time), 32'h0000);
        check("done_lap_ignored", 32'(lap_count), 32'h0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("cd_clear_disp", 32'(disp_time), 32'h3000);
        check("cd_clear_done", 32'(done), 32'h0);
        $display("countdown clear: disp=%h done=%0d", disp_time, done);

        // Alarm at 10.00 and wrap 59.99 -> 00.00
        mode_down = 1'b0;
        tick(2);
        check("up_idle_disp", 32'(disp_time), 32'h0000);
        pulse_ss();
        tick(999);
        check("alarm_before", 32'(alarm), 32'h0);
        tick(1);
        check("alarm_set", 32'(alarm), 32'h1);
        check("alarm_set_disp", 32'(disp_time), 32'h0999);
        tick(4999);
        check("alarm_held", 32'(alarm), 32'h1);
        check("pre_wrap_disp", 32'(disp_time), 32'h5998);
        tick(1);
        check("wrap_alarm_clr", 32'(alarm), 32'h0);
        check("wrap_disp_5999", 32'(disp_time), 32'h5999);
        tick(1);
        check("wrap_disp_zero", 32'(disp_time), 32'h0000);
        check("wrap_running", 32'(running), 32'h1);
        lap = 1'b1;
        tick(1);
        lap = 1'b0;
        check("wrap_continues", 32'(disp_time), 32'h0001);
        check("wrap_lap_count", 32'(lap_count), 32'h1);
        $display("alarm/wrap: disp=%h alarm=%0d lap_count=%0d", disp_time, alarm, lap_count);

        // Asynchronous reset mid-run, away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_disp", 32'(disp_time), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        check("async_rst_lap_count", 32'(lap_count), 32'h0);
        check("async_rst_lap_rd", 32'(lap_rd_time), 32'h0);
        check("async_rst_alarm_done", 32'({alarm, done}), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_idle_disp", 32'(disp_time), 32'h0);
        check("post_rst_idle_run", 32'(running), 32'h0);
        $display("async reset: disp=%h running=%0d", disp_time, running);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
